// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: bundle between the pipeline datapath and the hazard controller.
//   master : pipeline side; drives ID/EX/MEM hazard info and mem_busy,
//            receives the latch enables and flushes.
//   slave  : hazard controller side.
// Signals:
//   id_rs1/id_rs2, id_use_rs1/id_use_rs2 : ID source registers and use flags
//   branch, jump_reg, jump, branch_taken : ID control-flow info
//   id_ex_rd/id_ex_reg_we/id_ex_mem_re    : producer in EX
//   ex_mem_rd/ex_mem_reg_we/ex_mem_mem_re : producer in MEM
//   mem_busy                              : data memory freeze request
//   pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_we, mem_wb_we : controls
interface hazard_ctrl_if;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic       branch;
    logic       jump_reg;
    logic       jump;
    logic       branch_taken;
    logic [4:0] id_ex_rd;
    logic       id_ex_reg_we;
    logic       id_ex_mem_re;
    logic [4:0] ex_mem_rd;
    logic       ex_mem_reg_we;
    logic       ex_mem_mem_re;
    logic       mem_busy;
    logic       pc_we;
    logic       if_id_we;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       ex_mem_we;
    logic       mem_wb_we;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output branch, jump_reg, jump, branch_taken,
        output id_ex_rd, id_ex_reg_we, id_ex_mem_re,
        output ex_mem_rd, ex_mem_reg_we, ex_mem_mem_re,
        output mem_busy,
        input  pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_we, mem_wb_we
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  branch, jump_reg, jump, branch_taken,
        input  id_ex_rd, id_ex_reg_we, id_ex_mem_re,
        input  ex_mem_rd, ex_mem_reg_we, ex_mem_mem_re,
        input  mem_busy,
        output pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_we, mem_wb_we
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage core.
// Decides when forwarding cannot satisfy the ID instruction and inserts stall
// cycles/bubbles, flushes IF/ID on a redirect resolved in ID, freezes the whole
// pipeline while data memory is busy, and counts non-advancing cycles.
// Ports:
//   clk          : core clock
//   rst          : asynchronous, active-high reset
//   hz           : hazard_ctrl_if slave (hazard inputs, enables and flushes)
//   stall_cycles : saturating count of cycles with pc_we = 0
module hazard_ctrl #(
    parameter int unsigned STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    hazard_ctrl_if.slave           hz,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    typedef enum logic {IDLE, STALL} state_t;

    state_t     state, state_nxt;
    logic [1:0] cnt, cnt_nxt;
    logic       ex_hit, mem_hit, br_cons;
    logic [1:0] need;

    // Required stall count for the ID instruction; largest applicable case wins.
    always_comb begin
        ex_hit  = hz.id_ex_reg_we && (hz.id_ex_rd != '0) &&
                  ((hz.id_use_rs1 && (hz.id_rs1 == hz.id_ex_rd)) ||
                   (hz.id_use_rs2 && (hz.id_rs2 == hz.id_ex_rd)));
        mem_hit = hz.ex_mem_reg_we && (hz.ex_mem_rd != '0) &&
                  ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_mem_rd)) ||
                   (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_mem_rd)));
        br_cons = hz.branch || hz.jump_reg;
        need    = 2'd0;
        if (br_cons) begin
            if (ex_hit && hz.id_ex_mem_re)
                need = 2'd2;
            else if (ex_hit)
                need = 2'd1;
            else if (mem_hit && hz.ex_mem_mem_re)
                need = 2'd1;
        end else if (ex_hit && hz.id_ex_mem_re) begin
            need = 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A freeze holds both state and cnt, so frozen cycles extend a stall.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (!hz.mem_busy) begin
            unique case (state)
                IDLE: begin
                    if (need == 2'd2) begin
                        state_nxt = STALL;
                        cnt_nxt   = 2'd1;
                    end
                end
                STALL: begin
                    cnt_nxt = (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
                    if (cnt <= 2'd1)
                        state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs: reset values dominate, then freeze, then stall pattern, then advance.
    always_comb begin
        logic stall_pat;
        stall_pat      = (state == STALL) || (need != 2'd0);
        hz.pc_we       = 1'b0;
        hz.if_id_we    = 1'b0;
        hz.if_id_flush = 1'b0;
        hz.id_ex_flush = 1'b0;
        hz.ex_mem_we   = 1'b0;
        hz.mem_wb_we   = 1'b0;
        if (rst) begin
            hz.if_id_flush = 1'b1;
            hz.id_ex_flush = 1'b1;
        end else if (!hz.mem_busy) begin
            hz.ex_mem_we = 1'b1;
            hz.mem_wb_we = 1'b1;
            if (stall_pat) begin
                hz.id_ex_flush = 1'b1;
            end else begin
                hz.pc_we       = 1'b1;
                hz.if_id_we    = 1'b1;
                hz.if_id_flush = hz.jump || (hz.branch && hz.branch_taken);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cycles <= '0;
        else if (!hz.pc_we && (stall_cycles != '1))
            stall_cycles <= stall_cycles + STALL_CNT_W'(1);
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

- Pipeline hazard controller for the 5-stage core. It sits upstream of the forwarding unit and decides when forwarding alone cannot satisfy the instruction in ID.
- It inserts stall cycles and bubbles, and flushes IF/ID on a taken branch or jump resolved in ID.
- It freezes the whole pipeline while data memory is busy.
- It keeps a saturating stall-cycle counter for performance monitoring.

## Interface
Parameters:
- STALL_CNT_W, 32, width of the stall_cycles performance counter

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous, active-high reset
- id_rs1, id_rs2  input  5 each  source registers of the ID instruction
- id_use_rs1, id_use_rs2  input  1 each  ID instruction actually reads rs1 / rs2
- branch  input  1  ID holds a conditional branch (operands needed in ID)
- jump_reg  input  1  ID holds a jalr (rs1 needed in ID)
- jump  input  1  ID holds jal or jalr (unconditional redirect)
- branch_taken  input  1  ID branch comparison result
- id_ex_rd  input  5  rd of the instruction in EX
- id_ex_reg_we  input  1  EX instruction writes rd
- id_ex_mem_re  input  1  EX instruction is a load
- ex_mem_rd  input  5  rd of the instruction in MEM
- ex_mem_reg_we  input  1  MEM instruction writes rd
- ex_mem_mem_re  input  1  MEM instruction is a load
- mem_busy  input  1  data memory not ready; freeze request
- pc_we  output  1  PC register write enable
- if_id_we  output  1  IF/ID latch enable
- if_id_flush  output  1  clear IF/ID to a NOP on the next edge
- id_ex_flush  output  1  load a bubble into ID/EX on the next edge
- ex_mem_we, mem_wb_we  output  1 each  EX/MEM and MEM/WB latch enables
- stall_cycles  output  STALL_CNT_W  saturating count of non-advancing cycles

## Operation
- A register match counts only when rd != 0, the producer's reg_we = 1, and the corresponding id_use_rsN = 1.
- Required stall count N, evaluated only in IDLE; the largest applicable N wins:
  - Non-branch consumer, load in EX matches: N=1.
  - Branch/jump_reg consumer, non-load in EX matches: N=1.
  - Branch/jump_reg consumer, load in EX matches: N=2.
  - Branch/jump_reg consumer, load in MEM matches: N=1.
  - Otherwise N=0.
- FSM states: IDLE and STALL, plus a 2-bit counter cnt.
- IDLE, N>0:
  - Assert the stall pattern this cycle: pc_we=0, if_id_we=0, id_ex_flush=1.
  - If N=2, go to STALL with cnt=1. Otherwise remain in IDLE.
- STALL:
  - Assert the stall pattern; hazard detection is not evaluated.
  - cnt decrements each advancing cycle.
  - When cnt reaches 0, return to IDLE.
- IDLE, N=0:
  - pc_we=1, if_id_we=1, id_ex_flush=0.
  - if_id_flush=1 when jump=1, or when branch=1 and branch_taken=1. Otherwise if_id_flush=0.
- branch_taken and jump are ignored whenever the stall pattern or a freeze is active; no flush is issued in those cycles.
- Freeze (mem_busy=1) has top priority:
  - pc_we, if_id_we, ex_mem_we and mem_wb_we are all 0.
  - Both flushes are 0.
  - FSM state and cnt hold.
- ex_mem_we and mem_wb_we are 1 whenever there is no freeze. Data stalls do not block them.
- stall_cycles increments by 1 on every cycle with pc_we=0 outside reset, and saturates at all-ones.

## Timing
- Stall, flush and enable outputs are combinational from state, cnt and the current inputs; they take effect at the next clk edge.
- FSM state, cnt and stall_cycles update on the rising clk edge.
- Reset, asynchronous:
  - State = IDLE, cnt = 0, stall_cycles = 0.
  - While rst=1: pc_we=0, if_id_we=0, ex_mem_we=0, mem_wb_we=0, if_id_flush=1, id_ex_flush=1.
- Reset asserted mid-STALL aborts the stall immediately. The first cycle after release is evaluated from IDLE.
- Load-then-branch sequence: two consecutive stall cycles, and the branch resolves on the third cycle.
- Freeze during STALL:
  - Extends the stall by the frozen cycles without consuming cnt.
  - The stall pattern resumes once mem_busy drops.

## Test plan
- Load-use ALU case:
  - Stimulus: lw x5 in EX; add reading x5 in ID.
  - Response: exactly 1 cycle with pc_we=0 and id_ex_flush=1, then the add advances; stall_cycles=1.
- Branch after ALU op:
  - Stimulus: add x6 in EX; beq reading x6 in ID.
  - Response: 1 stall cycle, then normal advance.
- Branch after load:
  - Stimulus: lw x7 in EX; bne reading x7 in ID, taken.
  - Response: 2 stall cycles with if_id_flush=0, then 1 cycle with if_id_flush=1 and pc_we=1; stall_cycles=2.
- x0 and unused-operand cases:
  - Stimulus: lw x0 in EX with the ID instruction reading x0; and lw x5 with id_use_rs2=0 but id_rs2=5.
  - Response: no stall in either case.
- mem_busy during a 2-cycle stall:
  - Stimulus: raise mem_busy for 3 cycles during the first stall cycle.
  - Response: all enables 0, no flushes, cnt held; 5 total non-advancing cycles counted.
- Reset during STALL:
  - Stimulus: assert rst mid-stall.
  - Response: outputs take the reset values immediately; stall_cycles=0; after release with no hazard, pc_we=1 on the first cycle.
